// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: PS/2 keyboard frame deserialiser that folds E0/F0 prefixes into scan-code events.
// Define PS2_ERR_COUNT_EN to add the saturating err_count output.
module ps2_scan_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] scan_code,
    output logic        break_code,
`ifdef PS2_ERR_COUNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        finished
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_clk_sync, r_data_sync;
    logic        r_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_par_ok;
    logic [TW-1:0] r_tmo_cnt;
    logic        r_ext, r_brk;
    logic        w_clk_s, w_data, w_differ, w_toggle, w_fall, w_timeout, w_accept, w_err;

    assign w_clk_s   = r_clk_sync[1];
    assign w_data    = r_data_sync[1];
    assign w_differ  = w_clk_s != r_filt;
    assign w_toggle  = w_differ && r_filt_cnt == FW'(FILTER_LEN - 1);
    assign w_fall    = w_toggle && r_filt;
    assign w_timeout = r_state != IDLE && !w_fall && r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt      <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_filt_cnt  <= (w_differ && !w_toggle) ? r_filt_cnt + 1'b1 : '0;
            r_filt      <= r_filt ^ w_toggle;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_err      = 1'b0;
        if (w_timeout) begin
            w_state_nx = IDLE;
            w_err      = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    w_state_nx = w_data ? IDLE : DATA;
                DATA:    w_state_nx = (r_bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  w_state_nx = STOP;
                default: begin
                    w_state_nx = IDLE;
                    w_accept   = w_data && r_par_ok;
                    w_err      = !(w_data && r_par_ok);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_ok   <= 1'b0;
            r_tmo_cnt  <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            scan_code  <= '0;
            break_code <= 1'b0;
            finished   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            finished  <= 1'b0;
            r_tmo_cnt <= (r_state == IDLE || w_fall) ? '0 : r_tmo_cnt + 1'b1;
            if (w_fall && r_state == IDLE)
                r_bit_cnt <= '0;
            if (w_fall && r_state == DATA) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            // odd parity: data bits plus parity bit must hold an odd number of ones
            if (w_fall && r_state == PARITY)
                r_par_ok <= ^{w_data, r_shift};
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_accept) begin
                if (r_shift == 8'hE0)
                    r_ext <= 1'b1;
                else if (r_shift == 8'hF0)
                    r_brk <= 1'b1;
                else begin
                    scan_code  <= {r_ext ? 8'hE0 : 8'h00, r_shift};
                    break_code <= r_brk;
                    finished   <= 1'b1;
                    r_ext      <= 1'b0;
                    r_brk      <= 1'b0;
                end
            end
        end
    end

`ifdef PS2_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (w_err && err_count != 8'hFF)
            err_count <= err_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: table vectors, hand-written corner sequences and random frames vs an event model.
module tb_ps2_scan_decoder;
    localparam int HP = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] scan_code;
    logic        break_code;
    logic        finished;
`ifdef PS2_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    ps2_scan_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .scan_code(scan_code),
        .break_code(break_code),
`ifdef PS2_ERR_COUNT_EN
        .err_count(err_count),
`endif
        .finished(finished)
    );

    typedef struct {
        logic [2:0][7:0] b;
        int              n;
        int              bad_par;
        int              bad_stop;
        logic [15:0]     code;
        logic            brk;
    } vec_t;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    int          m_err = 0;
    vec_t        vecs[8];

    always @(negedge clk)
        if (!rst && finished) got_q.push_back({scan_code, break_code});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cyc(HP / 2);
            ps2_clk = 1'b0;
            cyc(HP);
            ps2_clk = 1'b1;
            cyc(HP / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_q.push_back({m_ext ? 8'hE0 : 8'h00, b, m_brk});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
        model_frame(b, !bad_par && !bad_stop);
        cyc(HP);
    endtask

    task automatic do_reset();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_err = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_single(input string name, input logic [15:0] code, input logic brk);
        cyc(30);
        check({name, " pulses"}, got_q.size(), 1);
        check({name, " code"}, scan_code, code);
        check({name, " brk"}, break_code, brk);
        check({name, " fin low"}, finished, 0);
        if (got_q.size() > 0) check({name, " pulse code"}, got_q[0][16:1], code);
    endtask

    initial begin
        vecs[0] = '{{8'h00, 8'h6B, 8'hE0}, 2, -1, -1, 16'hE06B, 1'b0};
        vecs[1] = '{{8'h74, 8'hF0, 8'hE0}, 3, -1, -1, 16'hE074, 1'b1};
        vecs[2] = '{{8'h00, 8'h1C, 8'hF0}, 2, -1, -1, 16'h001C, 1'b1};
        vecs[3] = '{{8'h75, 8'h6B, 8'hE0}, 3,  1, -1, 16'h0075, 1'b0};
        vecs[4] = '{{8'h00, 8'h00, 8'hE1}, 1, -1, -1, 16'h00E1, 1'b0};
        vecs[5] = '{{8'h75, 8'hE0, 8'hE0}, 3, -1, -1, 16'hE075, 1'b0};
        vecs[6] = '{{8'h1C, 8'hF0, 8'hF0}, 3, -1, -1, 16'h001C, 1'b1};
        vecs[7] = '{{8'h72, 8'h6B, 8'hE0}, 3, -1,  1, 16'h0072, 1'b0};

        do_reset();
        cyc(2);
        check("rst code", scan_code, 16'h0000);
        check("rst brk", break_code, 0);
        check("rst fin", finished, 0);
`ifdef PS2_ERR_COUNT_EN
        check("rst errcnt", err_count, 0);
`endif

        for (int v = 0; v < 8; v++) begin
            got_q.delete();
            exp_q.delete();
            for (int f = 0; f < vecs[v].n; f++)
                send_frame(vecs[v].b[f], f == vecs[v].bad_par, f == vecs[v].bad_stop);
            check_single($sformatf("vec%0d", v), vecs[v].code, vecs[v].brk);
        end
`ifdef PS2_ERR_COUNT_EN
        check("table errcnt", err_count, m_err);
`endif

        // mid-frame stall: start + 4 data bits, then clock idles past the timeout
        do_reset();
        send_bits({2'b11, 8'h72, 1'b0}, 5);
        cyc(3000);
        model_frame(8'h00, 1'b0);
        send_frame(8'h72, 1'b0, 1'b0);
        check_single("timeout", 16'h0072, 1'b0);
`ifdef PS2_ERR_COUNT_EN
        check("timeout errcnt", err_count, 1);
`endif

        do_reset();
        ps2_data = 1'b0;
        cyc(5);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(10);
        ps2_data = 1'b1;
        cyc(10);
        send_frame(8'h6B, 1'b0, 1'b0);
        check_single("glitch", 16'h006B, 1'b0);

        do_reset();
        send_bits({2'b11, 8'h74, 1'b0}, 7);
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_single("midrst", 16'hE075, 1'b0);

        do_reset();
        for (int s = 0; s < 20; s++) begin
            int n;
            got_q.delete();
            exp_q.delete();
            n = $urandom_range(1, 4);
            for (int f = 0; f < n; f++) begin
                int r, e;
                logic [7:0] b;
                r = $urandom_range(0, 9);
                e = $urandom_range(0, 9);
                b = (r < 3) ? 8'hE0 : (r < 5) ? 8'hF0 : 8'($urandom);
                send_frame(b, e == 0, e == 1);
            end
            cyc(30);
            check($sformatf("rnd%0d count", s), got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check($sformatf("rnd%0d ev%0d", s, i), got_q[i], exp_q[i]);
        end
`ifdef PS2_ERR_COUNT_EN
        check("rnd errcnt", err_count, m_err);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
